uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line rate in bit/s; DIV = CLK_HZ/BAUD (integer division, 868 at defaults); DIV < 2 SHALL be a elaboration-time error.
REQ-003 clk_i  in  1  single system clock; all logic on its rising edge.
REQ-004 rst_i  in  1  reset; synchronous, active-high.
REQ-005 valid0_i  in  1  requester 0 (core MMIO) has a byte.
REQ-006 data0_i  in  8  requester 0 byte.
REQ-007 ready0_o  out  1  requester 0 byte accepted this cycle when valid0_i also high.
REQ-008 valid1_i  in  1  requester 1 (loader/echo) has a byte.
REQ-009 data1_i  in  8  requester 1 byte.
REQ-010 ready1_o  out  1  requester 1 accept strobe, same rule.
REQ-011 tx_o  out  1  serial line, 8N1, idle high.
REQ-012 busy_o  out  1  high while a frame is on the line (state != IDLE).
REQ-013 grant_o  out  1  index of requester owning the current/last frame.

Function
REQ-014 FSM states IDLE, START, DATA, STOP; each bit period is exactly DIV clk_i cycles, timed by an internal counter 0..DIV-1.
REQ-015 IDLE: tx_o=1; at most one of ready0_o/ready1_o high, combinationally from valid*_i and last-grant register; never both.
REQ-016 Arbitration: only one valid -> that requester granted; both valid -> requester != last_grant granted (round-robin); none -> both ready low.
REQ-017 Transfer occurs on a cycle with valid&&ready; data latched into shift register, grant_o and last_grant updated, FSM -> START next cycle.
REQ-018 START: tx_o=0 for DIV cycles, then DATA.
REQ-019 DATA: 8 bits, LSB first, DIV cycles each, 3-bit bit counter; after bit 7 -> STOP.
REQ-020 STOP: tx_o=1 for DIV cycles, then IDLE.
REQ-021 Latency: tx_o falls the cycle after the transfer cycle; frame = 10*DIV cycles; min accept-to-accept spacing = 10*DIV+1 cycles.
REQ-022 ready*_o SHALL be low in START/DATA/STOP; valid held high meanwhile is not consumed and data*_i may change freely.
REQ-023 Requester deasserting valid before ready is permitted (no transfer, no state change).
REQ-024 Counter and bit-index arithmetic unsigned, width $clog2(DIV) and 3 bits; no wrap beyond terminal values.

Reset
REQ-025 On rst_i high at any clock edge: state=IDLE, tx_o=1, busy_o=0, ready*_o follow IDLE rule only after rst_i low (both low while rst_i high), grant_o=0, last_grant=1 (requester 0 wins first tie), counters=0.
REQ-026 Reset mid-frame aborts the frame; tx_o=1 on the following cycle; aborted byte is not retransmitted.

Structure
REQ-027 Package uart_pkg holds state enum tx_state_t, FRAME_BITS=10, DATA_BITS=8.
REQ-028 One sub-module uart_tx_shifter (baud counter, bit counter, shift register, tx_o); arbitration and handshake stay in uart_tx_arbiter.

Verification (bench uses CLK_HZ=400, BAUD=100 -> DIV=4)
REQ-029 Reset, no valid -> tx_o=1, busy_o=0, both ready low for 100 cycles.
REQ-030 valid0 with 0x55 -> ready0 for 1 cycle; tx_o = 0,1,0,1,0,1,0,1,0,1, each 4 cycles; busy high 40 cycles; grant_o=0.
REQ-031 valid0=0xA5 and valid1=0x3C same cycle, held -> 0xA5 frame then 0x3C frame, second transfer 41 cycles after first, grant_o 0 then 1.
REQ-032 Both valid continuously, four bytes each -> grants alternate 0,1,0,1,...; never both ready in one cycle.
REQ-033 rst_i pulsed 1 cycle during DATA bit 3 of 0xFF... byte 0x00 -> tx_o=1 next cycle, busy_o=0, next frame starts cleanly, requester 0 wins next tie.
REQ-034 valid1 pulsed 1 cycle while busy -> no ready1, no extra frame sent.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared state encoding and frame constants for the UART transmitter.
// Revision : 1.0
// ============================================================================
package uart_pkg;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_shifter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_shifter
// Brief    : 8N1 serialiser: baud counter, bit counter, shift register, tx line.
// Revision : 1.0
// ============================================================================
module uart_tx_shifter
  import uart_pkg::*;
#(
  parameter int DIV = 868
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int                 c_CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(DIV - 1);
  localparam logic [c_CNT_W-1:0] c_BAUD_ONE  = c_CNT_W'(1);
  localparam logic [2:0]         c_BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_t              r_state;
  tx_state_t              w_state_next;
  logic [c_CNT_W-1:0]     r_baud;
  logic [2:0]             r_bit;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   w_tick;
  logic                   w_tx;

  assign w_tick = (r_baud == c_BAUD_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start_i) w_state_next = ST_START;
      ST_START: if (w_tick) w_state_next = ST_DATA;
      ST_DATA:  if (w_tick && (r_bit == c_BIT_LAST)) w_state_next = ST_STOP;
      ST_STOP:  if (w_tick) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE) begin
        r_baud <= '0;
        r_bit  <= '0;
        if (start_i) r_shift <= data_i;
      end else begin
        r_baud <= w_tick ? '0 : r_baud + c_BAUD_ONE;
        // LSB is always the bit on the line; shift once per completed data bit
        if ((r_state == ST_DATA) && w_tick) begin
          r_shift <= r_shift >> 1;
          r_bit   <= (r_bit == c_BIT_LAST) ? '0 : r_bit + 3'd1;
        end
      end
    end
  end

  always_comb begin
    w_tx = 1'b1;
    case (r_state)
      ST_START: w_tx = 1'b0;
      ST_DATA:  w_tx = r_shift[0];
      default:  w_tx = 1'b1;
    endcase
  end

  assign tx_o   = w_tx;
  assign busy_o = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Two-requester round-robin front end feeding one 8N1 UART transmitter.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid0_i,
  input  logic [DATA_BITS-1:0] data0_i,
  output logic                 ready0_o,
  input  logic                 valid1_i,
  input  logic [DATA_BITS-1:0] data1_i,
  output logic                 ready1_o,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 grant_o
);

  localparam int c_DIV = CLK_HZ / BAUD;

  generate
    if (c_DIV < 2) begin : g_div_check
      $error("uart_tx_arbiter: CLK_HZ/BAUD must be at least 2");
    end
  endgenerate

  logic                 w_busy;
  logic                 w_idle;
  logic                 w_pick1;
  logic                 w_ready0;
  logic                 w_ready1;
  logic                 w_start;
  logic [DATA_BITS-1:0] w_data;
  logic                 r_grant;
  logic                 r_last_grant;

  // Requester 1 wins when alone or when requester 0 owned the previous frame
  assign w_idle   = !rst_i && !w_busy;
  assign w_pick1  = valid1_i && (!valid0_i || !r_last_grant);
  assign w_ready1 = w_idle && w_pick1;
  assign w_ready0 = w_idle && valid0_i && !w_pick1;
  assign w_start  = w_ready0 || w_ready1;
  assign w_data   = w_ready1 ? data1_i : data0_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_start) begin
      r_grant      <= w_pick1;
      r_last_grant <= w_pick1;
    end
  end

  uart_tx_shifter #(
    .DIV (c_DIV)
  ) u_shifter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (w_start),
    .data_i  (w_data),
    .tx_o    (tx_o),
    .busy_o  (w_busy)
  );

  assign ready0_o = w_ready0;
  assign ready1_o = w_ready1;
  assign busy_o   = w_busy;
  assign grant_o  = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Self-checking bench for uart_tx_arbiter with a frame-timing model.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int DIV   = 4;
  localparam int FRAME = 10 * DIV;

  logic       clk;
  logic       rst;
  logic       v0, v1;
  logic [7:0] d0, d1;
  logic       ready0, ready1, tx, busy, grant;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: age counts cycles since the accept edge (-1: never)
  int       m_age;
  logic [7:0] m_byte;
  logic     m_grant;
  logic     m_last;
  logic     xfer0, xfer1;

  uart_tx_arbiter #(
    .CLK_HZ (400),
    .BAUD   (100)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .valid0_i (v0),
    .data0_i  (d0),
    .ready0_o (ready0),
    .valid1_i (v1),
    .data1_i  (d1),
    .ready1_o (ready1),
    .tx_o     (tx),
    .busy_o   (busy),
    .grant_o  (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_tests++;
    n_fail++;
    $error("FAIL %s: timed out waiting for transfer", tag);
  endtask

  task automatic cycle();
    logic idle, e_r0, e_r1, e_tx, e_busy;
    int   k;
    @(negedge clk);
    e_busy = (m_age >= 0) && (m_age < FRAME);
    idle   = !rst && !e_busy;
    e_r1   = idle && v1 && (!v0 || !m_last);
    e_r0   = idle && v0 && !e_r1;
    e_tx   = 1'b1;
    if (e_busy) begin
      k = m_age / DIV;
      if (k == 0) e_tx = 1'b0;
      else if (k <= 8) e_tx = m_byte[k-1];
    end
    chk("ready0", ready0, e_r0);
    chk("ready1", ready1, e_r1);
    chk("ready_excl", ready0 && ready1, 1'b0);
    chk("tx", tx, e_tx);
    chk("busy", busy, e_busy);
    chk("grant", grant, m_grant);
    @(posedge clk);
    cyc++;
    xfer0 = e_r0;
    xfer1 = e_r1;
    if (rst) begin
      m_age   = -1;
      m_grant = 1'b0;
      m_last  = 1'b1;
    end else if (e_r0 || e_r1) begin
      m_age   = 0;
      m_byte  = e_r1 ? d1 : d0;
      m_grant = e_r1;
      m_last  = e_r1;
    end else if (e_busy) begin
      m_age++;
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_age >= 0) && (m_age < FRAME) && (n < 2 * FRAME)) begin
      cycle();
      n++;
    end
  endtask

  initial begin
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int   n, t0, t1;
    logic got0, got1, exp_who;

    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
    m_age = -1; m_byte = 8'h00; m_grant = 1'b0; m_last = 1'b1;
    xfer0 = 1'b0; xfer1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset held, then idle line with no requests
    run(3);
    rst = 1'b0;
    run(100);

    // Single byte 0x55 from requester 0
    v0 = 1'b1; d0 = 8'h55; n = 0; xfer0 = 1'b0;
    while (!xfer0 && n < 20) begin cycle(); n++; end
    if (!xfer0) timeout("single_55");
    v0 = 1'b0; d0 = 8'($urandom);
    run(FRAME + 5);

    // Simultaneous requests after reset: requester 0 first, 41 cycles apart
    rst = 1'b1; run(1); rst = 1'b0;
    v0 = 1'b1; d0 = 8'hA5; v1 = 1'b1; d1 = 8'h3C;
    got0 = 1'b0; got1 = 1'b0; t0 = 0; t1 = 0; n = 0;
    while (!(got0 && got1) && n < 200) begin
      cycle(); n++;
      if (xfer0) begin got0 = 1'b1; t0 = cyc; v0 = 1'b0; end
      if (xfer1) begin got1 = 1'b1; t1 = cyc; v1 = 1'b0; end
    end
    if (got0 && got1) chk_int("tie_spacing", t1 - t0, FRAME + 1);
    else timeout("tie_pair");
    wait_idle();

    // Four random bytes each, both valid throughout: grants alternate
    for (int i = 0; i < 4; i++) begin
      q0.push_back(8'($urandom));
      q1.push_back(8'($urandom));
    end
    exp_who = 1'b0; n = 0;
    while ((q0.size() + q1.size() > 0) && n < 1000) begin
      v0 = (q0.size() > 0); d0 = v0 ? q0[0] : 8'($urandom);
      v1 = (q1.size() > 0); d1 = v1 ? q1[0] : 8'($urandom);
      cycle(); n++;
      if (xfer0 || xfer1) begin
        chk("alt_grant", grant, exp_who);
        exp_who = !exp_who;
      end
      if (xfer0) void'(q0.pop_front());
      if (xfer1) void'(q1.pop_front());
    end
    if (q0.size() + q1.size() > 0) timeout("alternate");
    v0 = 1'b0; v1 = 1'b0;
    wait_idle();

    // Reset pulse during data bit 3 of 0xFF, then a clean tie goes to requester 0
    v0 = 1'b1; d0 = 8'hFF; n = 0; xfer0 = 1'b0;
    while (!xfer0 && n < 20) begin cycle(); n++; end
    if (!xfer0) timeout("abort_ff");
    v0 = 1'b0;
    while (m_age < 4 * DIV + 1 && m_age >= 0) cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", busy, 1'b0);
    v0 = 1'b1; d0 = 8'h00; v1 = 1'b1; d1 = 8'($urandom);
    n = 0; xfer0 = 1'b0; xfer1 = 1'b0;
    while (!(xfer0 || xfer1) && n < 20) begin cycle(); n++; end
    if (xfer0 || xfer1) chk("post_rst_grant", grant, 1'b0);
    else timeout("post_rst");
    v0 = 1'b0;
    n = 0; xfer1 = 1'b0;
    while (!xfer1 && n < 100) begin cycle(); n++; end
    if (!xfer1) timeout("post_rst_req1");
    v1 = 1'b0;
    wait_idle();

    // Requester 1 pulses valid while a frame is in flight
    v0 = 1'b1; d0 = 8'($urandom); n = 0; xfer0 = 1'b0;
    while (!xfer0 && n < 20) begin cycle(); n++; end
    if (!xfer0) timeout("busy_pulse");
    v0 = 1'b0;
    run(7);
    v1 = 1'b1; d1 = 8'($urandom);
    cycle();
    chk("pulse_no_ready1", ready1, 1'b0);
    v1 = 1'b0;
    run(FRAME + 5);
    chk("pulse_no_frame", busy, 1'b0);

    // Random traffic: valids may drop before acceptance, data changes freely
    for (int i = 0; i < 600; i++) begin
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 2) != 0);
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      cycle();
    end
    v0 = 1'b0; v1 = 1'b0;
    run(FRAME + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
